// File: rtl/imm_encoder.sv
// RV32I instruction packer with LI (LUI+ADDI) expansion; one registered output word, 1-cycle latency.
// Optional immediate range flagging via IMM_RANGE_CHECK_EN; outputs hold while out_valid && !out_ready.
module imm_encoder #(
    parameter logic [31:0] RESET_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_fmt,
    input  logic [6:0]  req_opcode,
    input  logic [2:0]  req_funct3,
    input  logic [6:0]  req_funct7,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic        out_last
);

    typedef enum logic [0:0] {IDLE, EMIT2} state_t;

    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_S  = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_U  = 3'd4;
    localparam logic [2:0] FMT_J  = 3'd5;
    localparam logic [2:0] FMT_LI = 3'd6;

    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_ADDI = 7'b0010011;

    state_t      state, state_nxt;
    logic [4:0]  pend_rd;
    logic [11:0] pend_lo;
    logic        accept;
    logic        out_fire;
    logic [31:0] enc_inst;
    logic        enc_err;
    logic        enc_last;
    logic        enc_two;
    logic [19:0] li_hi;
    logic        li_small;
    logic        range_err;

    assign req_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
    assign accept    = req_valid && req_ready;
    assign out_fire  = out_valid && out_ready;

    // LUI loads the upper part pre-compensated for the sign extension ADDI applies to lo.
    assign li_small = (&req_imm[31:11]) || (~|req_imm[31:11]);
    assign li_hi    = req_imm[31:12] + {19'd0, req_imm[11]};

`ifdef IMM_RANGE_CHECK_EN
    always_comb begin
        range_err = 1'b0;
        case (req_fmt)
            FMT_I, FMT_S: range_err = !((&req_imm[31:11]) || (~|req_imm[31:11]));
            FMT_B:        range_err = req_imm[0] || !((&req_imm[31:12]) || (~|req_imm[31:12]));
            FMT_J:        range_err = req_imm[0] || !((&req_imm[31:20]) || (~|req_imm[31:20]));
            FMT_U:        range_err = |req_imm[11:0];
            default:      range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    always_comb begin
        enc_inst = RESET_INST;
        enc_err  = 1'b0;
        enc_last = 1'b1;
        enc_two  = 1'b0;
        case (req_fmt)
            FMT_R: enc_inst = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, req_opcode};
            FMT_I: enc_inst = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode};
            FMT_S: enc_inst = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], req_opcode};
            FMT_B: enc_inst = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                               req_imm[4:1], req_imm[11], req_opcode};
            FMT_U: enc_inst = {req_imm[31:12], req_rd, req_opcode};
            FMT_J: enc_inst = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                               req_rd, req_opcode};
            FMT_LI: begin
                if (li_small) begin
                    enc_inst = {req_imm[11:0], 5'd0, 3'b000, req_rd, OP_ADDI};
                end else begin
                    enc_inst = {li_hi, req_rd, OP_LUI};
                    if (req_imm[11:0] != 12'd0) begin
                        enc_last = 1'b0;
                        enc_two  = 1'b1;
                    end
                end
            end
            default: enc_err = 1'b1;
        endcase
        if (range_err) begin
            enc_err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && enc_two) state_nxt = EMIT2;
            EMIT2:   if (out_fire)          state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_inst  <= RESET_INST;
            out_err   <= 1'b0;
            out_last  <= 1'b0;
            pend_rd   <= 5'd0;
            pend_lo   <= 12'd0;
        end else if (state == EMIT2) begin
            if (out_fire) begin
                out_valid <= 1'b1;
                out_inst  <= {pend_lo, pend_rd, 3'b000, pend_rd, OP_ADDI};
                out_err   <= 1'b0;
                out_last  <= 1'b1;
            end
        end else if (accept) begin
            out_valid <= 1'b1;
            out_inst  <= enc_inst;
            out_err   <= enc_err;
            out_last  <= enc_last;
            if (enc_two) begin
                pend_rd <= req_rd;
                pend_lo <= req_imm[11:0];
            end
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed-vector bench for imm_encoder; expected words are hand-encoded RV32I values.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_fmt;
    logic [6:0]  req_opcode;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic        out_last;

    int n_cmp = 0;
    int n_bad = 0;

    imm_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_fmt    (req_fmt),
        .req_opcode (req_opcode),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_imm    (req_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_err    (out_err),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
        req_fmt    = fmt;
        req_opcode = op;
        req_funct3 = f3;
        req_funct7 = f7;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_imm    = imm;
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        logic ok;
        ok = 1'b0;
        set_req(fmt, op, f3, f7, rd, rs1, rs2, imm);
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("accept", {31'd0, ok}, 32'd1);
        if (ok) begin
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] inst,
                               input logic err, input logic last);
        check({tag, "_vld"},  {31'd0, out_valid}, 32'd1);
        check({tag, "_inst"}, out_inst, inst);
        check({tag, "_err"},  {31'd0, out_err}, {31'd0, err});
        check({tag, "_last"}, {31'd0, out_last}, {31'd0, last});
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_idle"}, {31'd0, out_valid}, 32'd0);
    endtask

    logic exp_rc;

    initial begin
`ifdef IMM_RANGE_CHECK_EN
        exp_rc = 1'b1;
`else
        exp_rc = 1'b0;
`endif
        rst       = 1'b1;
        req_valid = 1'b1;
        out_ready = 1'b1;
        set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld",   {31'd0, out_valid}, 32'd0);
        check("rst_inst",  out_inst, 32'h0000_0013);
        check("rst_err",   {31'd0, out_err}, 32'd0);
        check("rst_last",  {31'd0, out_last}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        rst       = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", {31'd0, req_ready}, 32'd1);

        // Branch with negative offset: beq x1,x2,-4
        send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        expect_word("b_neg", 32'hFE20_8EE3, 1'b0, 1'b1);
        @(posedge clk); #1;
        expect_idle("b_neg");

        // LI needing LUI+ADDI with carry into hi
        send(3'd6, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
        expect_word("li2_lui", 32'h1234_62B7, 1'b0, 1'b0);
        check("li2_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        expect_word("li2_addi", 32'hFFF2_8293, 1'b0, 1'b1);
        @(posedge clk); #1;
        expect_idle("li2");

        // LI single ADDI and single LUI
        send(3'd6, 7'h00, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_07FF);
        expect_word("li_addi", 32'h7FF0_0093, 1'b0, 1'b1);
        send(3'd6, 7'h00, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'h0001_0000);
        expect_word("li_lui", 32'h0001_01B7, 1'b0, 1'b1);
        @(posedge clk); #1;
        expect_idle("li_lui");

        // I-type immediate just outside 12-bit signed range
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
        expect_word("i_ovf", 32'h8000_0093, exp_rc, 1'b1);

        // S-type: sw x5,-4(x2)
        send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 32'hFFFF_FFFC);
        expect_word("s_neg", 32'hFE51_2E23, 1'b0, 1'b1);

        // J-type: jal x1,+2048 then odd offset
        send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
        expect_word("j_ok", 32'h0010_00EF, 1'b0, 1'b1);
        send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0001);
        expect_word("j_odd", 32'h0000_00EF, exp_rc, 1'b1);

        // Reserved format
        send(3'd7, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0);
        expect_word("rsvd", 32'h0000_0013, 1'b1, 1'b1);
        @(posedge clk); #1;
        expect_idle("rsvd");

        // Backpressure: hold B word, R request waits, then R and U go back to back
        out_ready = 1'b0;
        send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        set_req(3'd0, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0);
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold", out_inst, 32'hFE20_8EE3);
            check("bp_ready", {31'd0, req_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        expect_word("bb_r", 32'h4031_00B3, 1'b0, 1'b1);
        set_req(3'd4, 7'h37, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'hABCD_E000);
        @(posedge clk); #1;
        expect_word("bb_u", 32'hABCD_E537, 1'b0, 1'b1);
        req_valid = 1'b0;
        @(posedge clk); #1;
        expect_idle("bb");

        // Reset while the ADDI of an LI is pending
        out_ready = 1'b0;
        send(3'd6, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
        expect_word("emit2_lui", 32'h1234_62B7, 1'b0, 1'b0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("mid_rst_vld",  {31'd0, out_valid}, 32'd0);
        check("mid_rst_inst", out_inst, 32'h0000_0013);
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 32'hFFFF_FFFC);
        expect_word("post_rst_s", 32'hFE51_2E23, 1'b0, 1'b1);
        @(posedge clk); #1;
        expect_idle("post_rst1");
        @(posedge clk); #1;
        expect_idle("post_rst2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the decode-side immediate extractor: takes an instruction format, opcode/funct/register fields and a 32-bit immediate, and packs them into a 32-bit RV32I instruction word.
- Also expands the LI pseudo-op into LUI+ADDI, or a single ADDI.
- Sits in the boot/patch and self-test path; its output feeds the instruction memory write port or test sequencer through a valid/ready handshake.

Parameters:
- RESET_INST, 32'h0000_0013, value held on out_inst during reset (NOP).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid && req_ready
- req_fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J 6=LI 7=reserved
- req_opcode  input  7  opcode[6:0]; ignored for LI
- req_funct3  input  3  funct3
- req_funct7  input  7  funct7 (R only)
- req_rd, req_rs1, req_rs2  input  5 each  register fields
- req_imm  input  32  byte-offset immediate, two's complement
- out_valid  output  1  out_inst valid
- out_ready  input  1  consumer accepts
- out_inst  output  32  encoded instruction
- out_err  output  1  immediate not representable (see Optional Feature)
- out_last  output  1  final word of the current request

Behaviour:
- FSM states: IDLE, EMIT2.
- Single output register holds out_valid, out_inst, out_err and out_last.
- Reset (async, rst=1): state=IDLE, out_valid=0, out_inst=RESET_INST, out_err=0, out_last=0, req_ready=0. Reset mid-LI drops the pending ADDI.
- req_ready = !rst && state==IDLE && (!out_valid || out_ready).
- Latency: accepted request appears on out_valid the next cycle. Back-to-back throughput is 1 word/cycle.
- out_* hold stable while out_valid && !out_ready.
- Packing by format:
  - R: {f7,rs2,rs1,f3,rd,op}
  - I: {imm[11:0],rs1,f3,rd,op}
  - S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
  - U: {imm[31:12],rd,op}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
- Reserved format: emit RESET_INST with out_err=1, out_last=1.
- LI rules:
  - If imm[31:11] are all equal: emit one ADDI rd,x0,imm[11:0], out_last=1, stay IDLE.
  - Else: hi = imm[31:12] + imm[11] (mod 2^20), lo = imm[11:0].
  - Emit LUI {hi,rd,7'b0110111}.
  - If lo != 0: out_last=0, go to EMIT2 and latch rd and lo. Else out_last=1.
- EMIT2: when out_valid && out_ready, load ADDI {lo,rd,3'b000,rd,7'b0010011} with out_last=1, then return to IDLE. req_ready=0 throughout EMIT2.
- Simultaneous events: an output handshake and a new request accept in the same cycle replace the register contents with no bubble.

Optional Feature:
- IMM_RANGE_CHECK_EN defined: out_err=1 for the word when the immediate is not representable:
  - I/S: imm[31:11] not all equal
  - B: imm[0]!=0 or imm[31:12] not all equal
  - J: imm[0]!=0 or imm[31:20] not all equal
  - U: imm[11:0]!=0
  - R and LI: never flag
- In every error case the word is still emitted with the truncated fields.
- Undefined: out_err is 1 only for reserved fmt; all other immediates are silently truncated.

Test Plan:
- fmt=B, op=7'h63, f3=0, rs1=1, rs2=2, imm=32'hFFFF_FFFC -> out_inst=32'hFE20_8EE3, out_err=0, out_last=1, one cycle after accept.
- fmt=LI, rd=5, imm=32'h1234_5FFF -> 32'h1234_62B7 (last=0), then 32'hFFF2_8293 (last=1). req_ready=0 between the two words.
- fmt=LI, rd=1, imm=32'h0000_07FF -> single 32'h7FF0_0093, last=1. fmt=LI, rd=3, imm=32'h0001_0000 -> single 32'h0001_01B7, last=1.
- fmt=I, op=7'h13, imm=32'h0000_0800 -> out_inst[31:20]=12'h800. out_err=1 with IMM_RANGE_CHECK_EN, out_err=0 without.
- Hold out_ready=0 for 5 cycles with req_valid=1 -> out_inst stable, no second request accepted. Release -> back-to-back words with no bubble.
- Assert rst while in EMIT2 -> out_valid=0 and out_inst=32'h0000_0013 immediately. After release, the next request encodes normally and the ADDI is never emitted.
